// File: rtl/mem_master_pkg.sv
// mem_master_pkg: state encoding and access latency constants for mem_master
package mem_master_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_LO_DATA = 3'd2;
  localparam logic [2:0] S_RD_HI = 3'd3;
  localparam logic [2:0] S_RD_HI_DATA = 3'd4;
  localparam logic [2:0] S_WR_LO = 3'd5;
  localparam logic [2:0] S_WR_HI = 3'd6;
  localparam logic [2:0] S_RESPOND = 3'd7;
  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    RD_LO = S_RD_LO,
    RD_LO_DATA = S_RD_LO_DATA,
    RD_HI = S_RD_HI,
    RD_HI_DATA = S_RD_HI_DATA,
    WR_LO = S_WR_LO,
    WR_HI = S_WR_HI,
    RESPOND = S_RESPOND
  } state_t;
  localparam int LAT_RD_BYTE = 3;
  localparam int LAT_RD_WORD = 5;
  localparam int LAT_WR_BYTE = 2;
  localparam int LAT_WR_WORD = 3;
endpackage

// File: rtl/mem_master.sv
// mem_master: byte/word request sequencer for a synchronous byte RAM with one-cycle read latency
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_word,
  input  logic [ADDR_WIDTH-1:0]   req_address,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [DATA_WIDTH-1:0]   ram_data_in,
  output logic                    ram_write_enable,
  input  logic [DATA_WIDTH-1:0]   ram_data_out
);
  state_t state, state_n;
  logic word_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] hi_q;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_n;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:       state_n = req_valid ? (req_write ? WR_LO : RD_LO) : IDLE;
      RD_LO:      state_n = RD_LO_DATA;
      RD_LO_DATA: state_n = word_q ? RD_HI : RESPOND;
      RD_HI:      state_n = RD_HI_DATA;
      RD_HI_DATA: state_n = RESPOND;
      WR_LO:      state_n = word_q ? WR_HI : RESPOND;
      WR_HI:      state_n = RESPOND;
      default:    state_n = IDLE;
    endcase
  end
  // rsp_data is cleared on accept so writes and byte reads return zero in unused bytes
  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_write_enable <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= state_n == RESPOND;
      case (state)
        IDLE: if (req_valid) begin
          word_q <= req_word;
          addr_q <= req_address;
          hi_q <= req_data[2*DATA_WIDTH-1:DATA_WIDTH];
          ram_address <= req_address;
          rsp_data <= '0;
          ram_write_enable <= req_write;
          if (req_write) ram_data_in <= req_data[DATA_WIDTH-1:0];
        end
        RD_LO_DATA: begin
          rsp_data[DATA_WIDTH-1:0] <= ram_data_out;
          if (word_q) ram_address <= addr_q + ADDR_WIDTH'(1);
        end
        RD_HI_DATA: rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= ram_data_out;
        WR_LO: if (word_q) begin
          ram_address <= addr_q + ADDR_WIDTH'(1);
          ram_data_in <= hi_q;
        end else ram_write_enable <= 1'b0;
        WR_HI: ram_write_enable <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
